// File: rtl/regfile_dump.sv
// Walks an inclusive address range of a register file through its combinational
// read port and streams each word out over a valid/ready handshake.
module regfile_dump #(
   parameter int N = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [N-1:0]  lo,
   input  logic [N-1:0]  hi,
   output logic [N-1:0]  ra,
   input  logic [31:0]   rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic [N-1:0]  out_addr,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  idx_q, idx_d;
   logic [N-1:0]  end_q, end_d;
   logic [31:0]   data_q, data_d;
   logic [N-1:0]  addr_q, addr_d;
   logic          last_q, last_d;

   // Next-state and datapath update; idx only advances after a non-final handshake,
   // so a range ending at the top address never wraps.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      end_d   = end_q;
      data_d  = data_q;
      addr_d  = addr_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (lo <= hi) begin
                  idx_d   = lo;
                  end_d   = hi;
                  state_d = S_READ;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            data_d  = rd;
            addr_d  = idx_q;
            last_d  = (idx_q == end_q);
            state_d = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + {{(N-1){1'b0}}, 1'b1};
                  state_d = S_READ;
               end
            end else begin
               state_d = S_SEND;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and captured-word registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= {N{1'b0}};
         end_q   <= {N{1'b0}};
         data_q  <= 32'd0;
         addr_q  <= {N{1'b0}};
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         end_q   <= end_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
      end
   end

   assign ra        = (state_q == S_READ) ? idx_q : {N{1'b0}};
   assign out_valid = (state_q == S_SEND);
   assign out_data  = data_q;
   assign out_addr  = addr_q;
   assign out_last  = last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dump, backpressure, single/empty range,
// ignored start, reset mid-dump and latency.
module tb_regfile_dump;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  lo;
   logic [4:0]  hi;
   logic [4:0]  ra;
   logic [31:0] rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_addr;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] rf [0:31];
   int          data_mode;
   int          checks = 0;
   int          failures = 0;

   logic [4:0]  wq_addr [$];
   logic [31:0] wq_data [$];
   logic        wq_last [$];

   always #5 clk = ~clk;

   assign rd = rf[ra];

   regfile_dump #(.N(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .lo        (lo),
      .hi        (hi),
      .ra        (ra),
      .rd        (rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_data(input int mode, input int a);
      if (mode == 0) return a * 3;
      else return 32'hC0DE_0000 + a * 17;
   endfunction

   task automatic fill(input int mode);
      data_mode = mode;
      for (int i = 0; i < 32; i++) rf[i] = exp_data(mode, i);
   endtask

   // Runs one dump; mode 0 = out_ready always high, mode 1 = ready on 3rd SEND cycle.
   task automatic do_dump(input logic [4:0] l, input logic [4:0] h, input int mode,
                          input int inject, output int nw, output int done_cyc,
                          output int last_hs, output int first_valid,
                          output logic [4:0] ra_first, output logic busy_ok);
      int          sendcnt;
      logic [31:0] hd;
      logic [4:0]  ha;
      logic        hl;
      bit          seen_done;
      wq_addr.delete(); wq_data.delete(); wq_last.delete();
      nw = 0; done_cyc = -1; last_hs = -1; first_valid = -1; ra_first = 5'd0;
      busy_ok = 1'b1; sendcnt = 0; hd = 32'd0; ha = 5'd0; hl = 1'b0; seen_done = 0;
      lo = l; hi = h; start = 1'b1;
      step();
      start = 1'b0; lo = ~l; hi = ~h;
      for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
         if (cyc == 1) ra_first = ra;
         if (done) begin
            done_cyc = cyc;
            seen_done = 1;
            check_eq("done_vs_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            if (!busy) busy_ok = 1'b0;
            if (out_valid) begin
               if (first_valid < 0) first_valid = cyc;
               if (sendcnt > 0) begin
                  check_eq("hold_data", out_data, hd);
                  check_eq("hold_addr", {27'd0, out_addr}, {27'd0, ha});
                  check_eq("hold_last", {31'd0, out_last}, {31'd0, hl});
               end
               hd = out_data; ha = out_addr; hl = out_last;
               out_ready = (mode == 0) ? 1'b1 : (sendcnt == 2);
               if (out_ready) begin
                  if (mode == 1) check_eq("bp_send_cycles", sendcnt, 32'd2);
                  wq_addr.push_back(out_addr);
                  wq_data.push_back(out_data);
                  wq_last.push_back(out_last);
                  nw++;
                  last_hs = cyc;
                  sendcnt = 0;
               end else begin
                  sendcnt++;
               end
            end else begin
               check_eq("ra_in_read", {27'd0, ra}, {27'd0, l} + nw);
               out_ready = (mode == 0);
            end
            if (cyc == inject) begin
               start = 1'b1; lo = 5'd0; hi = 5'd1;
            end else begin
               start = 1'b0; lo = ~l; hi = ~h;
            end
            step();
         end
      end
      out_ready = 1'b0;
      start = 1'b0;
      if (!seen_done) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic verify(input string tag, input int l, input int h, input int nw);
      check_eq({tag, "_count"}, nw, h - l + 1);
      for (int j = 0; j < wq_addr.size() && j <= h - l; j++) begin
         check_eq({tag, "_addr"}, {27'd0, wq_addr[j]}, l + j);
         check_eq({tag, "_data"}, wq_data[j], exp_data(data_mode, l + j));
         check_eq({tag, "_last"}, {31'd0, wq_last[j]}, (j == h - l) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic post_idle(input string tag);
      step();
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_ra_idle"}, {27'd0, ra}, 32'd0);
   endtask

   initial begin
      int          nw, dc, lh, fv;
      logic [4:0]  raf;
      logic        bok;
      bit          done_seen;

      reset = 1'b1; start = 1'b0; out_ready = 1'b0; lo = 5'd0; hi = 5'd0;
      fill(0);
      step(); step();
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_ra", {27'd0, ra}, 32'd0);
      check_eq("rst_data", out_data, 32'd0);
      check_eq("rst_addr", {27'd0, out_addr}, 32'd0);
      check_eq("rst_last", {31'd0, out_last}, 32'd0);
      reset = 1'b0;
      step();

      // Full dump 0..31 with ready held high.
      do_dump(5'd0, 5'd31, 0, -1, nw, dc, lh, fv, raf, bok);
      verify("full", 0, 31, nw);
      check_eq("full_ra_first", {27'd0, raf}, 32'd0);
      check_eq("full_first_valid", fv, 32'd2);
      check_eq("full_last_hs", lh, 32'd64);
      check_eq("full_done_cyc", dc, 32'd65);
      check_eq("full_busy", {31'd0, bok}, 32'd1);
      post_idle("full");

      // Backpressure 4..6.
      fill(1);
      do_dump(5'd4, 5'd6, 1, -1, nw, dc, lh, fv, raf, bok);
      verify("bp", 4, 6, nw);
      check_eq("bp_ra_first", {27'd0, raf}, 32'd4);
      check_eq("bp_done_cyc", dc, lh + 1);
      post_idle("bp");

      // Single word.
      do_dump(5'd7, 5'd7, 0, -1, nw, dc, lh, fv, raf, bok);
      verify("single", 7, 7, nw);
      check_eq("single_done_cyc", dc, 32'd3);
      post_idle("single");

      // Empty range.
      do_dump(5'd9, 5'd2, 0, -1, nw, dc, lh, fv, raf, bok);
      check_eq("empty_count", nw, 32'd0);
      check_eq("empty_first_valid", fv, 32'hFFFF_FFFF);
      check_eq("empty_done_cyc", dc, 32'd1);
      post_idle("empty");

      // Start pulsed mid-dump is ignored.
      do_dump(5'd10, 5'd12, 0, 3, nw, dc, lh, fv, raf, bok);
      verify("ignore", 10, 12, nw);
      check_eq("ignore_busy", {31'd0, bok}, 32'd1);
      post_idle("ignore");

      // Reset while SEND holds addr 3.
      fill(0);
      lo = 5'd0; hi = 5'd31; start = 1'b1;
      step();
      start = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid && out_addr == 5'd3) break;
         step();
      end
      check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd1);
      check_eq("rst_mid_addr", {27'd0, out_addr}, 32'd3);
      reset = 1'b1;
      step();
      reset = 1'b0; out_ready = 1'b0;
      check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_mid_data", out_data, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_seen = 1;
         step();
      end
      check_eq("rst_mid_no_done", {31'd0, done_seen}, 32'd0);
      do_dump(5'd0, 5'd31, 0, -1, nw, dc, lh, fv, raf, bok);
      verify("restart", 0, 31, nw);
      post_idle("restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
